// File: rtl/punc_mmio_responder_pkg.sv
// Shared constants for the PUnC LC3 device-page responder: default address map,
// register offsets, status bit positions and the request FSM encoding.
package punc_mmio_responder_pkg;

  localparam logic [15:0] DEF_BASE_ADDR = 16'hFE00;
  localparam logic [15:0] DEF_MCR_ADDR  = 16'hFFFE;
  localparam logic [15:0] DEF_PAGE_MASK = 16'hFE00;

  localparam logic [15:0] KBSR_OFS = 16'h0000;
  localparam logic [15:0] KBDR_OFS = 16'h0002;
  localparam logic [15:0] DSR_OFS  = 16'h0004;
  localparam logic [15:0] DDR_OFS  = 16'h0006;

  localparam int READY_BIT = 15;
  localparam int IE_BIT    = 14;
  localparam int OVR_BIT   = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/punc_mmio_responder_if.sv
// Datapath-side load/store request and response bus for the device page.
interface punc_mmio_responder_if;

  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        addr_hit;
  logic        resp_valid;
  logic [15:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, addr_hit, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, addr_hit, resp_valid, resp_rdata
  );

endinterface

// File: rtl/punc_mmio_stream_reg.sv
// Single-entry holding register; full_o is the occupancy status bit and the data
// stays readable after the entry drains.
module punc_mmio_stream_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             out_ready_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Fill only when empty and drain only when full, so the two never collide.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (out_ready_i && full_q) begin
      full_d = 1'b0;
    end
    if (in_valid_i && !full_q) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/punc_mmio_responder.sv
// PUnC LC3 device-page responder: KBSR/KBDR/DSR/DDR/MCR behind a two-cycle
// request/response handshake, bridged to byte-wide keyboard and display streams.
module punc_mmio_responder
  import punc_mmio_responder_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [15:0] MCR_ADDR  = DEF_MCR_ADDR,
  parameter logic [15:0] PAGE_MASK = DEF_PAGE_MASK
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  punc_mmio_responder_if.slave        bus,
  input  logic                        kb_valid_i,
  input  logic [7:0]                  kb_data_i,
  output logic                        kb_ready_o,
  output logic                        disp_valid_o,
  output logic [7:0]                  disp_data_o,
  input  logic                        disp_ready_i,
  output logic                        kb_irq_o,
  output logic                        halt_o
);

  localparam logic [15:0] KBSR_ADDR = BASE_ADDR + KBSR_OFS;
  localparam logic [15:0] KBDR_ADDR = BASE_ADDR + KBDR_OFS;
  localparam logic [15:0] DSR_ADDR  = BASE_ADDR + DSR_OFS;
  localparam logic [15:0] DDR_ADDR  = BASE_ADDR + DDR_OFS;

  state_e      state_q;
  logic        respValid_q;
  logic [15:0] respRdata_q;
  logic        kbIe_q;
  logic        dispOvr_q;
  logic [15:0] mcr_q;

  logic        accept, isLoad, isStore;
  logic        selKbsr, selKbdr, selDsr, selDdr, selMcr;
  logic        kbFull, dispFull;
  logic [7:0]  kbByte, dispByte;
  logic [15:0] readData;

  assign bus.addr_hit  = (bus.req_addr & PAGE_MASK) == BASE_ADDR;
  assign bus.req_ready = (state_q == IDLE);

  assign accept  = bus.req_valid && bus.req_ready;
  assign isLoad  = accept && !bus.req_we;
  assign isStore = accept && bus.req_we;

  assign selKbsr = bus.addr_hit && (bus.req_addr == KBSR_ADDR);
  assign selKbdr = bus.addr_hit && (bus.req_addr == KBDR_ADDR);
  assign selDsr  = bus.addr_hit && (bus.req_addr == DSR_ADDR);
  assign selDdr  = bus.addr_hit && (bus.req_addr == DDR_ADDR);
  assign selMcr  = bus.addr_hit && (bus.req_addr == MCR_ADDR);

  // Keyboard sink: filled by the stream, drained by a software KBDR load.
  punc_mmio_stream_reg #(.WIDTH(8)) u_kb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (kb_valid_i),
    .in_data_i   (kb_data_i),
    .out_ready_i (isLoad && selKbdr),
    .full_o      (kbFull),
    .data_o      (kbByte)
  );

  // Display source: filled by a DDR store while ready, drained by the display.
  punc_mmio_stream_reg #(.WIDTH(8)) u_disp (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (isStore && selDdr),
    .in_data_i   (bus.req_wdata[7:0]),
    .out_ready_i (disp_ready_i),
    .full_o      (dispFull),
    .data_o      (dispByte)
  );

  always_comb begin
    readData = 16'h0000;
    if (selKbsr)      readData = {kbFull, kbIe_q, 14'h0000};
    else if (selKbdr) readData = {8'h00, kbByte};
    else if (selDsr)  readData = {~dispFull, 14'h0000, dispOvr_q};
    else if (selDdr)  readData = {8'h00, dispByte};
    else if (selMcr)  readData = mcr_q;
  end

  // Read data is captured at acceptance, before any same-cycle stream event lands.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      respValid_q <= 1'b0;
      respRdata_q <= 16'h0000;
      kbIe_q      <= 1'b0;
      dispOvr_q   <= 1'b0;
      mcr_q       <= 16'h8000;
    end else begin
      if (state_q == IDLE) begin
        if (accept) begin
          state_q     <= RESP;
          respValid_q <= 1'b1;
          respRdata_q <= bus.req_we ? 16'h0000 : readData;
        end
      end else begin
        state_q     <= IDLE;
        respValid_q <= 1'b0;
      end

      if (isStore && selKbsr) kbIe_q <= bus.req_wdata[IE_BIT];

      if (isStore && selDsr && bus.req_wdata[OVR_BIT]) dispOvr_q <= 1'b0;
      else if (isStore && selDdr && dispFull)          dispOvr_q <= 1'b1;

      if (isStore && selMcr && mcr_q[READY_BIT]) mcr_q <= bus.req_wdata;
    end
  end

  assign bus.resp_valid = respValid_q;
  assign bus.resp_rdata = respRdata_q;
  assign kb_ready_o     = ~kbFull;
  assign kb_irq_o       = kbFull && kbIe_q;
  assign disp_valid_o   = dispFull;
  assign disp_data_o    = dispByte;
  assign halt_o         = ~mcr_q[READY_BIT];

endmodule

// File: tb/tb_punc_mmio_responder.sv
// Bench for punc_mmio_responder: directed register-map scenarios followed by random
// traffic, all checked against a register-level model of the device page.
module tb_punc_mmio_responder;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       kbValid = 1'b0;
  logic [7:0] kbData = 8'h00;
  logic       kbReady;
  logic       dispValid;
  logic [7:0] dispData;
  logic       dispReady = 1'b0;
  logic       kbIrq;
  logic       halt;

  int total = 0;
  int bad = 0;
  int respCount = 0;
  logic [15:0] lastResp = 16'h0000;

  bit       mBusy, mKbFull, mIe, mDispFull, mOvr;
  bit [7:0] mKbData, mDispData;
  bit [15:0] mMcr;

  punc_mmio_responder_if bus();

  punc_mmio_responder dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .bus          (bus),
    .kb_valid_i   (kbValid),
    .kb_data_i    (kbData),
    .kb_ready_o   (kbReady),
    .disp_valid_o (dispValid),
    .disp_data_o  (dispData),
    .disp_ready_i (dispReady),
    .kb_irq_o     (kbIrq),
    .halt_o       (halt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Register map as software sees it.
  function automatic logic [15:0] modelRead(input logic [15:0] a);
    if ((a & 16'hFE00) != 16'hFE00) return 16'h0000;
    case (a)
      16'hFE00: return {mKbFull, mIe, 14'h0000};
      16'hFE02: return {8'h00, mKbData};
      16'hFE04: return {~mDispFull, 14'h0000, mOvr};
      16'hFE06: return {8'h00, mDispData};
      16'hFFFE: return mMcr;
      default:  return 16'h0000;
    endcase
  endfunction

  task automatic doReset();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 16'h0; bus.req_wdata = 16'h0;
    kbValid = 1'b0; dispReady = 1'b0;
    rstN = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    mBusy = 0; mKbFull = 0; mIe = 0; mDispFull = 0; mOvr = 0;
    mKbData = 8'h00; mDispData = 8'h00; mMcr = 16'h8000;
    checkOutput("rst_resp_valid", bus.resp_valid, 1'b0);
    checkOutput("rst_resp_rdata", bus.resp_rdata, 16'h0000);
    checkOutput("rst_req_ready", bus.req_ready, 1'b1);
    checkOutput("rst_kb_ready", kbReady, 1'b1);
    checkOutput("rst_disp_valid", dispValid, 1'b0);
    checkOutput("rst_kb_irq", kbIrq, 1'b0);
    checkOutput("rst_halt", halt, 1'b0);
  endtask

  // One clock cycle: drive inputs, check live outputs, advance the model, check the response.
  task automatic applyStimulus(input logic v, input logic we, input logic [15:0] a, input logic [15:0] wd,
                               input logic kv, input logic [7:0] kd, input logic dr);
    bit acc, hit, preDispFull, kbAcc;
    logic [15:0] expRd;
    bus.req_valid = v; bus.req_we = we; bus.req_addr = a; bus.req_wdata = wd;
    kbValid = kv; kbData = kd; dispReady = dr;
    #1;
    hit = ((a & 16'hFE00) == 16'hFE00);
    checkOutput("req_ready", bus.req_ready, !mBusy);
    checkOutput("addr_hit", bus.addr_hit, hit);
    checkOutput("kb_ready", kbReady, !mKbFull);
    checkOutput("kb_irq", kbIrq, mKbFull && mIe);
    checkOutput("disp_valid", dispValid, mDispFull);
    if (mDispFull) checkOutput("disp_data", dispData, mDispData);
    checkOutput("halt", halt, !mMcr[15]);

    acc = v && !mBusy;
    expRd = (acc && !we) ? modelRead(a) : 16'h0000;
    preDispFull = mDispFull;
    kbAcc = kv && !mKbFull;
    if (acc && we && hit) begin
      case (a)
        16'hFE00: mIe = wd[14];
        16'hFE04: if (wd[0]) mOvr = 1'b0;
        16'hFE06: begin
          if (preDispFull) mOvr = 1'b1;
          else begin mDispFull = 1'b1; mDispData = wd[7:0]; end
        end
        16'hFFFE: if (mMcr[15]) mMcr = wd;
        default: ;
      endcase
    end
    if (acc && !we && a == 16'hFE02) mKbFull = 1'b0;
    if (kbAcc) begin mKbFull = 1'b1; mKbData = kd; end
    if (preDispFull && dr) mDispFull = 1'b0;

    @(posedge clk); #1;
    checkOutput("resp_valid", bus.resp_valid, acc);
    if (bus.resp_valid === 1'b1) begin
      respCount++;
      lastResp = bus.resp_rdata;
    end
    if (acc) checkOutput("resp_rdata", bus.resp_rdata, expRd);
    mBusy = acc;
  endtask

  task automatic idleCycle(input logic dr);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, dr);
  endtask

  task automatic readReg(input logic [15:0] a);
    applyStimulus(1'b1, 1'b0, a, 16'h0000, 1'b0, 8'h00, 1'b0);
    idleCycle(1'b0);
  endtask

  task automatic writeReg(input logic [15:0] a, input logic [15:0] wd, input logic dr);
    applyStimulus(1'b1, 1'b1, a, wd, 1'b0, 8'h00, dr);
    idleCycle(1'b0);
  endtask

  task automatic injectByte(input logic [7:0] b);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, b, 1'b0);
    idleCycle(1'b0);
  endtask

  initial begin
    int startCount;
    logic [15:0] addrPool [8];
    addrPool = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06, 16'hFFFE, 16'hFE08, 16'h3000, 16'h0000};

    doReset();
    readReg(16'hFE04); checkOutput("dsr_after_reset", lastResp, 16'h8000);
    readReg(16'hFFFE); checkOutput("mcr_after_reset", lastResp, 16'h8000);
    readReg(16'hFE00); checkOutput("kbsr_after_reset", lastResp, 16'h0000);

    injectByte(8'h41);
    checkOutput("kb_ready_full", kbReady, 1'b0);
    readReg(16'hFE00); checkOutput("kbsr_full", lastResp, 16'h8000);
    readReg(16'hFE02); checkOutput("kbdr_byte", lastResp, 16'h0041);
    readReg(16'hFE00); checkOutput("kbsr_cleared", lastResp, 16'h0000);
    checkOutput("kb_ready_again", kbReady, 1'b1);

    writeReg(16'hFE00, 16'h4000, 1'b0);
    injectByte(8'h0A);
    checkOutput("kb_irq_set", kbIrq, 1'b1);
    readReg(16'hFE02); checkOutput("kbdr_irq_byte", lastResp, 16'h000A);
    checkOutput("kb_irq_clear", kbIrq, 1'b0);

    writeReg(16'hFE06, 16'h1234, 1'b0);
    checkOutput("disp_valid_set", dispValid, 1'b1);
    checkOutput("disp_data_set", dispData, 8'h34);
    readReg(16'hFE04); checkOutput("dsr_busy", lastResp, 16'h0000);
    writeReg(16'hFE06, 16'h5678, 1'b0);
    readReg(16'hFE04); checkOutput("dsr_overrun", lastResp, 16'h0001);
    idleCycle(1'b1);
    readReg(16'hFE04); checkOutput("dsr_drained", lastResp, 16'h8001);
    checkOutput("disp_valid_clear", dispValid, 1'b0);
    readReg(16'hFE06); checkOutput("ddr_readback", lastResp, 16'h0034);
    writeReg(16'hFE04, 16'h0001, 1'b0);
    readReg(16'hFE04); checkOutput("dsr_ovr_cleared", lastResp, 16'h8000);

    // A DDR store landing in the same cycle as the drain still counts as busy.
    writeReg(16'hFE06, 16'h00AA, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hFE06, 16'h00BB, 1'b0, 8'h00, 1'b1);
    idleCycle(1'b0);
    readReg(16'hFE04); checkOutput("dsr_drain_collision", lastResp, 16'h8001);
    writeReg(16'hFE04, 16'h0001, 1'b0);

    writeReg(16'hFE08, 16'hFFFF, 1'b0);
    readReg(16'hFE08); checkOutput("unmapped_in_page", lastResp, 16'h0000);

    writeReg(16'hFFFE, 16'h0000, 1'b0);
    checkOutput("halt_set", halt, 1'b1);
    writeReg(16'hFFFE, 16'h8000, 1'b0);
    readReg(16'hFFFE); checkOutput("mcr_sticky", lastResp, 16'h0000);
    doReset();
    readReg(16'hFFFE); checkOutput("mcr_after_halt_reset", lastResp, 16'h8000);

    startCount = respCount;
    applyStimulus(1'b1, 1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0, 8'h00, 1'b0);
    idleCycle(1'b0);
    checkOutput("b2b_resp_count", respCount - startCount, 2);
    checkOutput("unmapped_read", lastResp, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] a, wd;
      int idx;
      if (i == 200) doReset();
      idx = $urandom_range(0, 7);
      a = (idx == 7) ? 16'($urandom) : addrPool[idx];
      wd = 16'($urandom);
      if (a == 16'hFFFE && ($urandom % 16) != 0) wd[15] = 1'b1;
      applyStimulus(1'($urandom), 1'($urandom), a, wd, 1'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
